// File: rtl/ebpf_divmod_seq_if.sv
// Handshake bundle between the eBPF pipeline (master) and the sequential divide/modulo unit (slave).
interface ebpf_divmod_seq_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DST_W  = 4
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              in_is_mod;
    logic              in_is_64;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [DST_W-1:0]  in_dst;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [DST_W-1:0]  out_dst;
    logic              busy;

    modport master (
        output flush, in_valid, in_is_mod, in_is_64, in_a, in_b, in_dst, out_ready,
        input  in_ready, out_valid, out_result, out_dst, busy
    );

    modport slave (
        input  flush, in_valid, in_is_mod, in_is_64, in_a, in_b, in_dst, out_ready,
        output in_ready, out_valid, out_result, out_dst, busy
    );
endinterface

// File: rtl/ebpf_divmod_seq.sv
// Multi-cycle unsigned BPF_DIV/BPF_MOD unit (ALU64 and ALU32) using restoring division,
// one quotient bit per cycle, with valid/ready handshakes on both sides.
module ebpf_divmod_seq #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DST_W  = 4
) (
    input logic               clk,
    input logic               rst_n,
    ebpf_divmod_seq_if.slave  bus
);
    localparam int unsigned HALF_W = DATA_W / 2;
    localparam int unsigned CNT_W  = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CntLast64 = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CntLast32 = CNT_W'(HALF_W - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q, state_d;
    logic [DATA_W:0]   rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] div_q, div_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_mod_q, is_mod_d;
    logic [DST_W-1:0]  dst_q, dst_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;

    logic [DATA_W-1:0] a_eff, b_eff, quo_load;
    logic [DATA_W:0]   rem_shift, rem_diff, rem_next;
    logic [DATA_W-1:0] quo_next;
    logic              ge, accept;

    assign a_eff    = bus.in_is_64 ? bus.in_a : {{HALF_W{1'b0}}, bus.in_a[HALF_W-1:0]};
    assign b_eff    = bus.in_is_64 ? bus.in_b : {{HALF_W{1'b0}}, bus.in_b[HALF_W-1:0]};
    // ALU32 dividend is left-aligned so the same MSB-first loop runs for 32 iterations.
    assign quo_load = bus.in_is_64 ? bus.in_a : {bus.in_a[HALF_W-1:0], {HALF_W{1'b0}}};
    assign accept   = bus.in_valid && (state_q == StIdle) && !bus.flush;

    assign rem_shift = {rem_q[DATA_W-1:0], quo_q[DATA_W-1]};
    assign rem_diff  = rem_shift - {1'b0, div_q};
    assign ge        = rem_q[DATA_W] | ~rem_diff[DATA_W];
    assign rem_next  = ge ? rem_diff : rem_shift;
    assign quo_next  = {quo_q[DATA_W-2:0], ge};

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        is_mod_d = is_mod_q;
        dst_d    = dst_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    is_mod_d = bus.in_is_mod;
                    dst_d    = bus.in_dst;
                    busy_d   = 1'b1;
                    if (b_eff == '0) begin
                        res_d   = bus.in_is_mod ? a_eff : '0;
                        valid_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        rem_d   = '0;
                        quo_d   = quo_load;
                        div_d   = b_eff;
                        cnt_d   = bus.in_is_64 ? CntLast64 : CntLast32;
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                rem_d = rem_next;
                quo_d = quo_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    res_d   = is_mod_q ? rem_next[DATA_W-1:0] : quo_next;
                    valid_d = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
        if (bus.flush) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            is_mod_q <= 1'b0;
            dst_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            is_mod_q <= is_mod_d;
            dst_q    <= dst_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.in_ready   = (state_q == StIdle);
    assign bus.out_valid  = valid_q;
    assign bus.out_result = res_q;
    assign bus.out_dst    = dst_q;
    assign bus.busy       = busy_q;
endmodule

// File: doc/ebpf_divmod_seq.md
# ebpf_divmod_seq

Multi-cycle unsigned divide/modulo execution unit for the eBPF core. It sits between operand fetch/decode and register writeback. It is the sequential replacement path for the single-cycle combinational divider when timing closure requires it. It implements eBPF BPF_DIV/BPF_MOD semantics for both ALU64 and ALU32 classes, including the defined divide-by-zero results, behind valid/ready handshakes on both sides.

## Interface
- DATA_W, 64, operand/result width; only 64 is supported.
- DST_W, 4, width of the destination-register tag carried through (eBPF r0..r10).

- clk  input  1  core clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset. The block has one clock; reset asserts asynchronously and is active-low.
- flush  input  1  synchronous abort from the pipeline (branch/exception); drops any in-flight op.
- in_valid  input  1  operands present.
- in_ready  output  1  unit can accept; high only in IDLE.
- in_is_mod  input  1  1 = modulo (BPF_MOD), 0 = divide (BPF_DIV).
- in_is_64  input  1  1 = ALU64, 0 = ALU32.
- in_a  input  DATA_W  dividend (dst register value).
- in_b  input  DATA_W  divisor (src register or sign-extended imm, already resolved upstream).
- in_dst  input  DST_W  destination register tag.
- out_valid  output  1  result present.
- out_ready  input  1  writeback accepts result.
- out_result  output  DATA_W  quotient or remainder.
- out_dst  output  DST_W  tag captured at accept.
- busy  output  1  high in CALC or DONE.

## Operation
- States are IDLE, CALC, and DONE. Reset forces IDLE. All registered outputs reset to 0: out_valid=0, out_result=0, out_dst=0, busy=0. in_ready = (state==IDLE), so it is 1 out of reset.
- Accept happens when in_valid & in_ready & !flush. The unit captures is_mod, is_64, and dst.
  - ALU32: a and b are truncated to bits [31:0]. N=32.
  - ALU64: a and b are taken as full 64-bit values. N=64.
- All arithmetic is unsigned, as eBPF DIV/MOD are unsigned.
- Zero divisor is checked on the effective (truncated) b at accept. On zero divisor the unit skips CALC and goes directly to DONE:
  - DIV result = 0.
  - MOD result = effective a; in ALU32 this is a[31:0] zero-extended.
- Nonzero divisor goes IDLE->CALC. The unit performs restoring shift-subtract division, one quotient bit per cycle, MSB first.
  - The partial remainder register is 65 bits wide.
  - Iteration counter counts N-1 down to 0. When the counter reaches 0 the unit goes CALC->DONE.
- In DONE, out_valid=1.
  - out_result = quotient (DIV) or final remainder (MOD).
  - ALU32 results are zero-extended to 64 bits, with upper 32 bits = 0.
  - out_result and out_dst stay stable while out_valid & !out_ready.
  - DONE->IDLE occurs on out_ready. out_valid drops the next cycle.
- flush in any state forces the state to IDLE on the next edge with out_valid=0. Any result not yet accepted is discarded. If flush and out_ready are high in the same DONE cycle, the transfer counts as taken; the state still goes to IDLE.
- flush with in_valid in IDLE: no accept.
- No overlap: a new op is accepted only in IDLE. This gives at most one op per N+2 cycles, plus any backpressure stall.

## Timing
- Cycle 0 is the accept edge.
- Nonzero divisor: out_valid is first high in cycle N+1, i.e. cycle 33 for ALU32 and cycle 65 for ALU64.
- Zero divisor: out_valid is high in cycle 1.
- in_ready returns high the cycle after the out_valid & out_ready handshake.
- Asynchronous reset mid-CALC or mid-DONE: outputs clear immediately and state goes to IDLE. No result is produced after reset deasserts.
- No combinational path from in_* to out_*.
- in_ready depends on state only, not on out_ready.

## Test plan
- ALU64 DIV with a=100, b=7 -> out_result=14, out_dst=captured tag, out_valid at cycle 65. ALU64 MOD with the same operands -> 2.
- ALU32 DIV with a=0xFFFFFFFF_00000010, b=0x00000001_00000003 -> upper bits are ignored, out_result=0x5, out_valid at cycle 33. ALU64 DIV with a=0xFFFFFFFF_FFFFFFFF, b=0x1 -> 0xFFFFFFFF_FFFFFFFF.
- Zero divisor, both checked at cycle 1:
  - ALU32 MOD with a=0xDEADBEEF_12345678, b=0xABCD0000_00000000 (effective b=0) -> 0x00000000_12345678.
  - ALU64 DIV with b=0 -> 0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid, out_result, and out_dst are stable and in_ready=0. Raise out_ready -> in_ready=1 the following cycle.
- Flush mid-CALC at cycle 20 of an ALU64 op -> IDLE next cycle, no out_valid ever, and the next op (a=9, b=3 DIV) returns 3 correctly. Flush together with in_valid in IDLE -> not accepted.
- Assert rst_n=0 asynchronously mid-CALC and mid-DONE -> out_valid=0, out_result=0, and busy=0 immediately. After release, in_ready=1 and a fresh op completes correctly.
